sdram_port_arbiter: RTL and testbench
=====================================

// Module: sdram_port_arbiter
// PURPOSE
//  N-channel read/write front-end for sdram2m_controller's req/ack/burst interface, on the SDRAM clock.
//  Replaces hard-wired per-client muxing: each channel (CPU line fill, single write, burst writer, VGA fetch)
//  posts addr/len/dir; block arbitrates, runs one burst at a time, streams data, pulses done.
//  Generalises channel count, widths, burst length and arbitration mode.
// PARAMETERS
//  NUM_CH   4   number of client channels (1..8)
//  ADDR_W   20  word address width
//  DATA_W   16  data width
//  BURST_W  10  burst length field width (len 1..2^BURST_W-1)
//  RR_MODE  1   1 = round-robin, 0 = fixed priority (lowest index wins)
// PORTS
//  clk             in   1               SDRAM controller clock; all logic on posedge
//  rst_n           in   1               asynchronous active-low reset
//  ch_req          in   NUM_CH          per-channel request level
//  ch_we           in   NUM_CH          1 = write burst, 0 = read burst
//  ch_addr         in   NUM_CH*ADDR_W   start address, channel i at [i*ADDR_W +: ADDR_W]
//  ch_len          in   NUM_CH*BURST_W  burst length in words
//  ch_wdata        in   NUM_CH*DATA_W   show-ahead write word per channel
//  ch_gnt          out  NUM_CH          one-hot grant, held for whole transaction
//  ch_wr_next      out  NUM_CH          write word consumed; present next word after this edge
//  ch_rd_valid     out  NUM_CH          ch_rdata valid for channel i
//  ch_rdata        out  DATA_W          shared read data bus
//  ch_done         out  NUM_CH          1-cycle completion pulse
//  busy            out  1               transaction in progress (state != IDLE)
//  sdram_wr_req/sdram_wr_addr/sdram_wr_burst/sdram_din   out  1/ADDR_W/BURST_W/DATA_W  to controller
//  sdram_wr_ack    in   1               controller consumes sdram_din this cycle
//  sdram_rd_req/sdram_rd_addr/sdram_rd_burst             out  1/ADDR_W/BURST_W  to controller
//  sdram_rd_ack    in   1               sdram_dout valid this cycle
//  sdram_dout      in   DATA_W          read data from controller
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, word counter 0, RR pointer = NUM_CH-1 (first RR grant = ch0). Reset mid-burst aborts immediately.
//  FSM IDLE -> XFER -> DONE -> IDLE.
//  IDLE: if any ch_req, pick winner (RR: first requester after last granted index, wrapping; fixed: lowest index);
//   register gnt, addr, len, we; next state XFER. Latency ch_req edge -> ch_gnt/sdram_*_req high: 1 cycle.
//   Winner with len==0: no SDRAM access, go straight to DONE.
//  XFER: sdram_wr_req (we=1) or sdram_rd_req (we=0) held high; addr/burst driven from latched values, stable.
//   Write: sdram_din = ch_wdata of granted channel (combinational mux); ch_wr_next[g] = sdram_wr_ack.
//   Read: ch_rdata <= sdram_dout, ch_rd_valid[g] <= sdram_rd_ack (1-cycle registered).
//   Counter (BURST_W bits) increments per ack; on ack with count==len-1: req drops next edge, state DONE.
//   Acks beyond len or from the other direction ignored. RR pointer updated to granted index.
//  DONE: ch_done[g]=1 for one cycle; ch_gnt cleared on exit; -> IDLE.
//  Client rule: drop ch_req on the edge ch_done is sampled high, else a new transaction starts from IDLE.
//   ch_req deasserted during XFER is ignored; burst completes (controller cannot abort).
//   ch_addr/len/we sampled only in IDLE; changes afterwards have no effect.
//  Never both sdram_wr_req and sdram_rd_req high; at most one ch_gnt bit set; no idle gap beyond DONE+IDLE (2 cycles) between bursts.
// TESTING
//  Single read ch0 addr 0x00400 len 4, model returns A0..A3 -> 4 ch_rd_valid pulses A0..A3, ch_done 1 cycle after last.
//  Write ch2 addr 0x00010 len 16, data 0..15 -> model memory 0x10..0x1F = 0..15, 16 ch_wr_next pulses.
//  RR_MODE=1, ch0..ch3 all requesting len 1 repeatedly -> grant order 0,1,2,3,0; fixed mode -> ch0 starves others.
//  len=0 on ch1 -> ch_done within 2 cycles, no sdram_*_req asserted.
//  rst_n low mid 16-word write -> all outputs 0 asynchronously; after release, next request from ch0 granted first.
//  ch_req dropped at word 3 of len-8 read -> all 8 words delivered, ch_done still pulses.

Source files
------------

// File: rtl/sdram_port_arbiter.sv
// Multi-channel burst front-end for the SDRAM controller req/ack interface.
// Arbitrates between client channels, runs one burst at a time, streams data and pulses done.
module sdram_port_arbiter #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned ADDR_W  = 20,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned BURST_W = 10,
  parameter int unsigned RR_MODE = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_CH-1:0]         ch_req,
  input  logic [NUM_CH-1:0]         ch_we,
  input  logic [NUM_CH*ADDR_W-1:0]  ch_addr,
  input  logic [NUM_CH*BURST_W-1:0] ch_len,
  input  logic [NUM_CH*DATA_W-1:0]  ch_wdata,
  output logic [NUM_CH-1:0]         ch_gnt,
  output logic [NUM_CH-1:0]         ch_wr_next,
  output logic [NUM_CH-1:0]         ch_rd_valid,
  output logic [DATA_W-1:0]         ch_rdata,
  output logic [NUM_CH-1:0]         ch_done,
  output logic                      busy,
  output logic                      sdram_wr_req,
  output logic [ADDR_W-1:0]         sdram_wr_addr,
  output logic [BURST_W-1:0]        sdram_wr_burst,
  output logic [DATA_W-1:0]         sdram_din,
  input  logic                      sdram_wr_ack,
  output logic                      sdram_rd_req,
  output logic [ADDR_W-1:0]         sdram_rd_addr,
  output logic [BURST_W-1:0]        sdram_rd_burst,
  input  logic                      sdram_rd_ack,
  input  logic [DATA_W-1:0]         sdram_dout
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_e;

  state_e             state_q, state_d;
  logic [NUM_CH-1:0]  gnt_q, gnt_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   rr_q, rr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BURST_W-1:0] len_q, len_d;
  logic [BURST_W-1:0] cnt_q, cnt_d;
  logic               we_q, we_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic [NUM_CH-1:0]  rd_valid_q, rd_valid_d;

  logic               found;
  logic [IDX_W-1:0]   win;
  logic [IDX_W-1:0]   cand_idx;
  int unsigned        cand;
  logic               wr_act, rd_act, ack;

  // Round-robin scans starting just after the last granted index; fixed mode scans from 0.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (RR_MODE != 0) cand = (32'(rr_q) + 1 + k) % NUM_CH;
      else              cand = k;
      cand_idx = IDX_W'(cand);
      if (!found && ch_req[cand_idx]) begin
        found = 1'b1;
        win   = cand_idx;
      end
    end
  end

  assign wr_act = (state_q == S_XFER) && we_q;
  assign rd_act = (state_q == S_XFER) && !we_q;
  assign ack    = (wr_act && sdram_wr_ack) || (rd_act && sdram_rd_ack);

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    idx_d      = idx_q;
    rr_d       = rr_q;
    addr_d     = addr_q;
    len_d      = len_q;
    we_d       = we_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    rd_valid_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          gnt_d      = '0;
          gnt_d[win] = 1'b1;
          idx_d      = win;
          rr_d       = win;
          addr_d     = ch_addr[win*ADDR_W +: ADDR_W];
          len_d      = ch_len[win*BURST_W +: BURST_W];
          we_d       = ch_we[win];
          cnt_d      = '0;
          state_d    = (ch_len[win*BURST_W +: BURST_W] == '0) ? S_DONE : S_XFER;
        end
      end
      S_XFER: begin
        if (rd_act && sdram_rd_ack) begin
          rdata_d    = sdram_dout;
          rd_valid_d = gnt_q;
        end
        if (ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        gnt_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      gnt_q      <= '0;
      idx_q      <= '0;
      rr_q       <= IDX_W'(NUM_CH - 1);
      addr_q     <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      rdata_q    <= '0;
      rd_valid_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      idx_q      <= idx_d;
      rr_q       <= rr_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      rdata_q    <= rdata_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Controller-side buses are held at zero outside an active burst of that direction.
  assign sdram_wr_req   = wr_act;
  assign sdram_wr_addr  = wr_act ? addr_q : '0;
  assign sdram_wr_burst = wr_act ? len_q  : '0;
  assign sdram_din      = wr_act ? ch_wdata[idx_q*DATA_W +: DATA_W] : '0;
  assign sdram_rd_req   = rd_act;
  assign sdram_rd_addr  = rd_act ? addr_q : '0;
  assign sdram_rd_burst = rd_act ? len_q  : '0;

  assign ch_gnt      = gnt_q;
  assign ch_wr_next  = (wr_act && sdram_wr_ack) ? gnt_q : '0;
  assign ch_rd_valid = rd_valid_q;
  assign ch_rdata    = rdata_q;
  assign ch_done     = (state_q == S_DONE) ? gnt_q : '0;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: behavioural SDRAM controller model plus linear test steps.
module tb_sdram_port_arbiter;

  localparam int unsigned NUM_CH  = 4;
  localparam int unsigned ADDR_W  = 20;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned BURST_W = 10;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic [NUM_CH-1:0]         ch_req, ch_we;
  logic [NUM_CH*ADDR_W-1:0]  ch_addr;
  logic [NUM_CH*BURST_W-1:0] ch_len;
  logic [NUM_CH*DATA_W-1:0]  ch_wdata = '0;
  logic [NUM_CH-1:0]         ch_gnt, ch_wr_next, ch_rd_valid, ch_done;
  logic [DATA_W-1:0]         ch_rdata;
  logic                      busy;
  logic                      sdram_wr_req, sdram_rd_req;
  logic [ADDR_W-1:0]         sdram_wr_addr, sdram_rd_addr;
  logic [BURST_W-1:0]        sdram_wr_burst, sdram_rd_burst;
  logic [DATA_W-1:0]         sdram_din;
  logic                      sdram_wr_ack = 1'b0, sdram_rd_ack = 1'b0;
  logic [DATA_W-1:0]         sdram_dout = '0;

  // fixed-priority instance with an always-acking controller
  logic [NUM_CH-1:0]         f_gnt, f_wr_next, f_rd_valid, f_done;
  logic [DATA_W-1:0]         f_rdata, f_din;
  logic                      f_busy, f_wr_req, f_rd_req;
  logic [ADDR_W-1:0]         f_wr_addr, f_rd_addr;
  logic [BURST_W-1:0]        f_wr_burst, f_rd_burst;

  always #5 clk = ~clk;

  sdram_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .RR_MODE(1)) dut (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_wdata(ch_wdata), .ch_gnt(ch_gnt), .ch_wr_next(ch_wr_next), .ch_rd_valid(ch_rd_valid),
    .ch_rdata(ch_rdata), .ch_done(ch_done), .busy(busy),
    .sdram_wr_req(sdram_wr_req), .sdram_wr_addr(sdram_wr_addr), .sdram_wr_burst(sdram_wr_burst),
    .sdram_din(sdram_din), .sdram_wr_ack(sdram_wr_ack),
    .sdram_rd_req(sdram_rd_req), .sdram_rd_addr(sdram_rd_addr), .sdram_rd_burst(sdram_rd_burst),
    .sdram_rd_ack(sdram_rd_ack), .sdram_dout(sdram_dout));

  sdram_port_arbiter #(.NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W), .RR_MODE(0)) dut_fix (
    .clk(clk), .rst_n(rst_n), .ch_req(ch_req), .ch_we(ch_we), .ch_addr(ch_addr), .ch_len(ch_len),
    .ch_wdata(ch_wdata), .ch_gnt(f_gnt), .ch_wr_next(f_wr_next), .ch_rd_valid(f_rd_valid),
    .ch_rdata(f_rdata), .ch_done(f_done), .busy(f_busy),
    .sdram_wr_req(f_wr_req), .sdram_wr_addr(f_wr_addr), .sdram_wr_burst(f_wr_burst),
    .sdram_din(f_din), .sdram_wr_ack(f_wr_req),
    .sdram_rd_req(f_rd_req), .sdram_rd_addr(f_rd_addr), .sdram_rd_burst(f_rd_burst),
    .sdram_rd_ack(f_rd_req), .sdram_dout(16'h0000));

  int checks = 0;
  int errors = 0;

  // ---------------- controller / client model (sole driver of its signals) ----------------
  logic [DATA_W-1:0] mem [0:2047];
  logic [DATA_W-1:0] rd_q[$];
  int glog[$];
  int flog[$];
  int cyc = 0, tick = 0, mw = 0, mr = 0, widx = 0;
  int wnext_cnt = 0, done_cnt = 0, done_cyc = -1, last_rd_ack_cyc = -1, req_cycles = 0, viol = 0;
  bit wnext_prev = 1'b0;
  logic [NUM_CH-1:0] prev_gnt = '0, prev_fgnt = '0;

  function automatic logic [DATA_W-1:0] rom(input logic [ADDR_W-1:0] a);
    if (a >= 20'h00400 && a < 20'h00410) return 16'h00A0 + DATA_W'(a - 20'h00400);
    if (a >= 20'h00100 && a < 20'h00110) return 16'h5500 + DATA_W'(a - 20'h00100);
    return a[DATA_W-1:0];
  endfunction

  function automatic int onehot_idx(input logic [NUM_CH-1:0] v);
    for (int i = 0; i < NUM_CH; i++) if (v[i]) return i;
    return -1;
  endfunction

  always @(negedge clk) begin
    logic [ADDR_W-1:0] a;
    cyc++;
    if (!ch_gnt[2]) widx = 0;
    else if (wnext_prev) widx++;
    ch_wdata = '0;
    ch_wdata[2*DATA_W +: DATA_W] = DATA_W'(widx);
    #1;
    tick++;
    sdram_wr_ack = 1'b0;
    sdram_rd_ack = 1'b0;
    if (sdram_wr_req) begin
      if (tick % 3 != 0) begin
        sdram_wr_ack = 1'b1;
        a = sdram_wr_addr + ADDR_W'(mw);
        mem[a[10:0]] = sdram_din;
        mw++;
      end
    end else mw = 0;
    if (sdram_rd_req) begin
      if (tick % 3 != 0) begin
        sdram_rd_ack = 1'b1;
        a = sdram_rd_addr + ADDR_W'(mr);
        sdram_dout = rom(a);
        last_rd_ack_cyc = cyc;
        mr++;
      end
    end else mr = 0;
    #1;
    wnext_prev = ch_wr_next[2];
    if (|ch_wr_next) wnext_cnt++;
    if (|ch_rd_valid) rd_q.push_back(ch_rdata);
    if (|ch_done) begin done_cnt++; done_cyc = cyc; end
    if (sdram_wr_req || sdram_rd_req) req_cycles++;
    if (ch_gnt != '0 && prev_gnt == '0) glog.push_back(onehot_idx(ch_gnt));
    if (f_gnt != '0 && prev_fgnt == '0) flog.push_back(onehot_idx(f_gnt));
    prev_gnt  = ch_gnt;
    prev_fgnt = f_gnt;
    if ((sdram_wr_req && sdram_rd_req) || $countones(ch_gnt) > 1 || $countones(f_gnt) > 1) viol++;
  end

  // ---------------- helpers ----------------
  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic setup(input int ch, input logic we, input logic [ADDR_W-1:0] addr, input logic [BURST_W-1:0] len);
    ch_we[ch] = we;
    ch_addr[ch*ADDR_W +: ADDR_W] = addr;
    ch_len[ch*BURST_W +: BURST_W] = len;
  endtask

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic wait_done(input int ch, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (ch_done[ch]) begin
        ch_req[ch] = 1'b0;
        ok = 1'b1;
        break;
      end
    end
    ch_req[ch] = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int b_rd, b_done, b_wn, b_req, c0, b_g, b_f;
    bit all0;
    rst_n   = 1'b0;
    ch_req  = '0;
    ch_we   = '0;
    ch_addr = '0;
    ch_len  = '0;
    step(); step();
    check("reset_outputs",
          {ch_gnt, ch_wr_next, ch_rd_valid, ch_rdata, ch_done, busy, sdram_wr_req, sdram_wr_addr,
           sdram_wr_burst, sdram_din, sdram_rd_req, sdram_rd_addr, sdram_rd_burst}, '0);
    rst_n = 1'b1;
    step();

    // single read, ch0
    b_rd = rd_q.size(); b_done = done_cnt;
    setup(0, 1'b0, 20'h00400, 10'd4);
    ch_req[0] = 1'b1;
    step();
    check("rd_grant_latency", {ch_gnt, sdram_rd_req, sdram_wr_req, sdram_rd_addr, sdram_rd_burst},
          {4'b0001, 1'b1, 1'b0, 20'h00400, 10'd4});
    wait_done(0, 100, ok);
    check("rd_done_seen", ok, 1'b1);
    check("rd_word_count", rd_q.size() - b_rd, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rd_word%0d", i), rd_q[b_rd + i], 16'h00A0 + i);
    check("rd_done_pulses", done_cnt - b_done, 1);
    check("rd_done_timing", done_cyc, last_rd_ack_cyc + 1);

    // 16-word write, ch2
    b_wn = wnext_cnt; b_done = done_cnt;
    setup(2, 1'b1, 20'h00010, 10'd16);
    ch_req[2] = 1'b1;
    wait_done(2, 200, ok);
    check("wr_done_seen", ok, 1'b1);
    all0 = 1'b1;
    for (int i = 0; i < 16; i++) if (mem[16 + i] !== 16'(i)) all0 = 1'b0;
    check("wr_memory", all0, 1'b1);
    check("wr_next_pulses", wnext_cnt - b_wn, 16);
    check("wr_done_pulses", done_cnt - b_done, 1);

    // zero-length request, ch1
    step();
    b_req = req_cycles; c0 = cyc;
    setup(1, 1'b1, 20'h00050, 10'd0);
    ch_req[1] = 1'b1;
    wait_done(1, 10, ok);
    check("len0_done_seen", ok, 1'b1);
    check("len0_done_within_2", (done_cyc - c0) <= 2, 1'b1);
    check("len0_no_sdram_req", req_cycles - b_req, 0);

    // read with request dropped at word 3, ch1
    step();
    b_rd = rd_q.size(); b_done = done_cnt;
    setup(1, 1'b0, 20'h00100, 10'd8);
    ch_req[1] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (rd_q.size() - b_rd >= 3) break;
    end
    ch_req[1] = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (done_cnt != b_done) break;
      step();
    end
    check("drop_word_count", rd_q.size() - b_rd, 8);
    all0 = 1'b1;
    for (int i = 0; i < 8; i++) if (rd_q[b_rd + i] !== 16'h5500 + i) all0 = 1'b0;
    check("drop_word_data", all0, 1'b1);
    check("drop_done_pulses", done_cnt - b_done, 1);

    // round-robin vs fixed priority with all four channels requesting
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < NUM_CH; i++) setup(i, 1'b0, 20'h00300 + ADDR_W'(i), 10'd1);
    b_g = glog.size(); b_f = flog.size();
    ch_req = 4'b1111;
    for (int i = 0; i < 200; i++) begin
      step();
      if (glog.size() - b_g >= 5) break;
    end
    ch_req = '0;
    repeat (10) step();
    for (int i = 0; i < 5; i++) check($sformatf("rr_order%0d", i), glog[b_g + i], i % 4);
    all0 = 1'b1;
    for (int i = b_f; i < flog.size(); i++) if (flog[i] != 0) all0 = 1'b0;
    check("fixed_ch0_starves", {flog.size() - b_f >= 3, all0}, 2'b11);

    // asynchronous reset in the middle of a 16-word write
    b_wn = wnext_cnt;
    setup(2, 1'b1, 20'h00200, 10'd16);
    ch_req[2] = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wnext_cnt - b_wn >= 5) break;
    end
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          {ch_gnt, ch_wr_next, ch_rd_valid, ch_rdata, ch_done, busy, sdram_wr_req, sdram_wr_addr,
           sdram_wr_burst, sdram_din, sdram_rd_req, sdram_rd_addr, sdram_rd_burst}, '0);
    ch_req = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    setup(0, 1'b0, 20'h00600, 10'd1);
    setup(3, 1'b0, 20'h00700, 10'd1);
    ch_req = 4'b1001;
    step();
    check("post_reset_grant_ch0", ch_gnt, 4'b0001);
    ch_req[3] = 1'b0;
    wait_done(0, 50, ok);
    check("post_reset_done_seen", ok, 1'b1);
    repeat (3) step();

    check("invariants", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
